// File: rtl/thermo_decoder_gen.sv
// Binary-to-thermometer decoder with a direct path and a self-test sweep FSM; registered output.
// Latency: 1 cycle from input acceptance to out_valid. Back-pressure: out_ready=0 holds the output and drops in_ready.
module thermo_decoder_gen #(
    parameter int BIN_WIDTH    = 5,
    parameter int THERMO_WIDTH = 32,
    parameter int SWEEP_GAP    = 3
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    start,
    input  logic [BIN_WIDTH-1:0]    bin_in,
    input  logic                    in_valid,
    output logic                    in_ready,
    output logic [THERMO_WIDTH-1:0] thermo_out,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic                    busy,
    output logic                    done
);

    typedef enum logic [1:0] {IDLE, EMIT, GAP, DONE} state_t;

    localparam int GAP_W = (SWEEP_GAP > 1) ? $clog2(SWEEP_GAP) : 1;
    localparam logic [GAP_W-1:0]     GAP_LAST = GAP_W'((SWEEP_GAP > 0) ? SWEEP_GAP - 1 : 0);
    localparam logic [BIN_WIDTH-1:0] CNT_MAX  = '1;

    state_t                 state_q, state_d;
    logic [BIN_WIDTH-1:0]   cnt_q;
    logic [GAP_W-1:0]       gap_q;
    logic                   emitted_q;

    logic                   free, accept, dir_load, sweep_load, emit_accept, last;
    logic [BIN_WIDTH-1:0]   sweep_val;

    function automatic logic [THERMO_WIDTH-1:0] decode(input logic [BIN_WIDTH-1:0] v);
        return ~({THERMO_WIDTH{1'b1}} << v);
    endfunction

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: if (start) state_d = EMIT;
            EMIT: if (emit_accept) begin
                if (last)               state_d = DONE;
                else if (SWEEP_GAP > 0) state_d = GAP;
                else                    state_d = EMIT;
            end
            GAP:  if (gap_q == GAP_LAST) state_d = EMIT;
            DONE: state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Output / control logic
    always_comb begin
        busy        = (state_q != IDLE);
        done        = (state_q == DONE);
        free        = !out_valid || out_ready;
        accept      = out_valid && out_ready;
        in_ready    = rst_n && (state_q == IDLE) && !start && free;
        dir_load    = in_valid && in_ready;
        emit_accept = (state_q == EMIT) && emitted_q && accept;
        last        = (cnt_q == CNT_MAX);
        sweep_load  = 1'b0;
        sweep_val   = cnt_q;
        case (state_q)
            EMIT: begin
                if (!emitted_q && free) begin
                    sweep_load = 1'b1;
                end else if (emit_accept && !last && (SWEEP_GAP == 0)) begin
                    // Zero gap: the next code replaces the accepted one in the same cycle.
                    sweep_load = 1'b1;
                    sweep_val  = cnt_q + 1'b1;
                end
            end
            // Loading on the last gap cycle keeps the idle run exactly SWEEP_GAP long.
            GAP:     sweep_load = (gap_q == GAP_LAST);
            default: sweep_load = 1'b0;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q     <= '0;
            gap_q     <= '0;
            emitted_q <= 1'b0;
        end else begin
            if (state_q == IDLE && start)
                cnt_q <= '0;
            else if (emit_accept && !last)
                cnt_q <= cnt_q + 1'b1;

            if (state_q == GAP && gap_q != GAP_LAST)
                gap_q <= gap_q + 1'b1;
            else
                gap_q <= '0;

            if (sweep_load)
                emitted_q <= 1'b1;
            else if (emit_accept || state_q == IDLE)
                emitted_q <= 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            thermo_out <= '0;
            out_valid  <= 1'b0;
        end else if (dir_load) begin
            thermo_out <= decode(bin_in);
            out_valid  <= 1'b1;
        end else if (sweep_load) begin
            thermo_out <= decode(sweep_val);
            out_valid  <= 1'b1;
        end else if (accept) begin
            out_valid  <= 1'b0;
        end
    end

endmodule
